cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter CHAIN_LEN, default `CLB_CONFIG_LEN + 2*`LUT_CONFIG_LEN (36): configuration chain length in bits.
REQ-002 Parameter WORD_W, default 8: width of input and readback words.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a load pass; honoured only in IDLE.
REQ-006 abort  input  1  terminate the current pass.
REQ-007 in_data  input  WORD_W  configuration word, LSB shifted first.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 shift_clk  output  1  registered chain clock to the CLB shift_clk ports.
REQ-011 shift_i  output  1  registered serial data to the chain head.
REQ-012 shift_o  input  1  serial data from the chain tail.
REQ-013 rb_data  output  WORD_W  readback word of previous chain contents.
REQ-014 rb_valid  output  1  one-cycle strobe qualifying rb_data; no backpressure.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on pass completion.

Function
REQ-017 FSM states: IDLE, WAIT_WORD, SETUP, PULSE, FINISH.
REQ-018 IDLE: start=1 and abort=0 -> WAIT_WORD; bit counter and readback packer cleared.
REQ-019 WAIT_WORD: in_ready=1; a handshake (in_valid & in_ready) latches in_data and moves to SETUP; otherwise hold with shift_clk=0 indefinitely.
REQ-020 SETUP: shift_i = current word bit, shift_clk=0; shift_o sampled at the edge ending SETUP as readback bit n.
REQ-021 PULSE: shift_clk=1, shift_i held; bit counter increments at the edge ending PULSE.
REQ-022 After PULSE: counter = CHAIN_LEN -> FINISH; else word bits remain -> SETUP; else -> WAIT_WORD.
REQ-023 Each bit costs exactly 2 clk cycles; shift_i never changes in the same cycle shift_clk rises.
REQ-024 Exactly CHAIN_LEN shift_clk pulses per completed pass; unused upper bits of the final word are discarded.
REQ-025 FINISH: done=1 for one cycle, then IDLE.
REQ-026 Readback bits pack LSB first; rb_valid pulses the cycle after every WORD_W-th sample; after the final sample a partial word is emitted zero-padded in its upper bits.
REQ-027 abort in any non-IDLE state: next state IDLE, shift_clk=0, no done, no partial rb word.
REQ-028 start while busy is ignored; start and abort together in IDLE leave IDLE unchanged.
REQ-029 in_ready is 0 in every state except WAIT_WORD.
REQ-030 The counter is $clog2(CHAIN_LEN+1) bits wide and never wraps.

Reset
REQ-031 rst=1 forces IDLE; shift_clk, shift_i, in_ready, busy, done, rb_valid and rb_data go to 0 at the next edge.
REQ-032 rst mid-pass takes precedence over all inputs; a partially shifted chain is left as-is.

Structure
REQ-033 FSM state encodings `CFGL_IDLE..`CFGL_FINISH are added to defs.v beside the CLB/LUT length macros.
REQ-034 The block is a single module with no sub-modules; all outputs are driven from flops.

Verification
REQ-035 CHAIN_LEN=36, WORD_W=8, in_valid held high, words encoding AND3 on x / XOR3 on y -> 36 pulses, done at cycle 2*36+5+2, CLB truth table matches the standalone CLB bench.
REQ-036 Same load with in_valid low for 10 cycles before word 3 -> shift_clk stays 0 during the stall; final chain contents are identical.
REQ-037 Load pattern A, then pattern B -> 5 rb_valid strobes reproduce A, the fifth holding A bits 35:32 zero-padded.
REQ-038 abort after 17 pulses -> IDLE next cycle, no done, exactly 17 pulses seen; a following full load succeeds.
REQ-039 rst asserted in PULSE -> shift_clk=0 and busy=0 next cycle; start while busy and start+abort in IDLE -> no effect.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
// Shared definitions for the configuration-chain loader.
//   - Chain length building blocks (one CLB config field plus two LUT fields)
//   - FSM state encoding used by cfg_loader
//   - idx_w(): width helper for bit/word indices that stays legal for n == 1
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

  localparam int CLB_CONFIG_LEN = 4;
  localparam int LUT_CONFIG_LEN = 16;

  // Default chain: CLB config bits followed by two LUT truth tables (36 bits).
  localparam int CHAIN_LEN_DEF  = CLB_CONFIG_LEN + 2 * LUT_CONFIG_LEN;
  localparam int WORD_W_DEF     = 8;

  typedef enum logic [2:0] {
    CFGL_IDLE      = 3'd0,
    CFGL_WAIT_WORD = 3'd1,
    CFGL_SETUP     = 3'd2,
    CFGL_PULSE     = 3'd3,
    CFGL_FINISH    = 3'd4
  } cfgl_state_e;

  // Index width for a field of n bits; a 1-bit field still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_loader_if
// Bundles the loader's control, word-stream, chain and readback signals.
//   start, abort          pass control (host -> loader)
//   in_data/in_valid      configuration word stream (host -> loader)
//   in_ready              word accepted this cycle (loader -> host)
//   shift_clk, shift_i    chain clock and serial data (loader -> chain)
//   shift_o               serial data from the chain tail (chain -> loader)
//   rb_data/rb_valid      readback of previous chain contents (loader -> host)
//   busy, done            status (loader -> host)
// Modports: master = host/chain side, slave = loader.
// ---------------------------------------------------------------------------
interface cfg_loader_if
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              start;
  logic              abort;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              shift_clk;
  logic              shift_i;
  logic              shift_o;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, in_data, in_valid, shift_o,
    input  in_ready, shift_clk, shift_i, rb_data, rb_valid, busy, done
  );

  modport slave (
    input  start, abort, in_data, in_valid, shift_o,
    output in_ready, shift_clk, shift_i, rb_data, rb_valid, busy, done
  );

endinterface

// File: rtl/cfg_loader.sv
// ---------------------------------------------------------------------------
// cfg_loader
// Streams CHAIN_LEN configuration bits (LSB of each word first) into a serial
// configuration chain, two clk cycles per bit: SETUP presents the data bit
// with shift_clk low, PULSE raises shift_clk with the data held. The bit
// leaving the chain tail is captured at the end of each SETUP and packed into
// WORD_W-bit readback words, so a pass also returns the previous contents.
//
// Ports:
//   clk  system clock, all state on its rising edge
//   rst  synchronous active-high reset
//   bus  cfg_loader_if.slave (see interface for signal list)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input logic        clk,
  input logic        rst,
  cfg_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = idx_w(WORD_W);

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORD_W - 1);

  cfgl_state_e       state;
  logic [CNT_W-1:0]  cnt;       // bits fully shifted this pass
  logic [IDX_W-1:0]  bit_idx;   // bit of the held word currently on shift_i
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] rb_pack;   // readback bits gathered so far
  logic [IDX_W-1:0]  rb_idx;

  logic              in_ready_q;
  logic              shift_clk_q;
  logic              shift_i_q;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  next_cnt;
  logic [IDX_W-1:0]  next_idx;

  assign next_cnt = cnt + 1'b1;
  assign next_idx = bit_idx + 1'b1;

  // NOTE: every register here, including the word and readback storage, is
  // cleared in the synchronous reset branch so reset leaves no stale readback.
  // NOTE: all state is written with non-blocking assignments so each branch
  // below reads the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CFGL_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      word        <= '0;
      rb_pack     <= '0;
      rb_idx      <= '0;
      in_ready_q  <= 1'b0;
      shift_clk_q <= 1'b0;
      shift_i_q   <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rb_valid_q <= 1'b0;

      if (state != CFGL_IDLE && bus.abort) begin
        // Abort drops the pass on the spot: no done, no partial readback.
        state       <= CFGL_IDLE;
        shift_clk_q <= 1'b0;
        in_ready_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          CFGL_IDLE: begin
            if (bus.start && !bus.abort) begin
              state      <= CFGL_WAIT_WORD;
              cnt        <= '0;
              rb_pack    <= '0;
              rb_idx     <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end

          CFGL_WAIT_WORD: begin
            if (bus.in_valid && in_ready_q) begin
              word       <= bus.in_data;
              bit_idx    <= '0;
              shift_i_q  <= bus.in_data[0];
              in_ready_q <= 1'b0;
              state      <= CFGL_SETUP;
            end
          end

          CFGL_SETUP: begin
            shift_clk_q <= 1'b1;
            state       <= CFGL_PULSE;
            // The tail bit seen now is old chain bit number cnt. Emit on a
            // full word or on the last bit of the chain (upper bits stay 0).
            if (rb_idx == LAST_IDX || cnt == LAST_SAMPLE) begin
              rb_data_q  <= rb_pack | (WORD_W'(bus.shift_o) << rb_idx);
              rb_valid_q <= 1'b1;
              rb_pack    <= '0;
              rb_idx     <= '0;
            end else begin
              rb_pack[rb_idx] <= bus.shift_o;
              rb_idx          <= rb_idx + 1'b1;
            end
          end

          CFGL_PULSE: begin
            shift_clk_q <= 1'b0;
            cnt         <= next_cnt;
            if (next_cnt == LAST_CNT) begin
              // Remaining bits of the final word are never shifted.
              state  <= CFGL_FINISH;
              done_q <= 1'b1;
            end else if (bit_idx != LAST_IDX) begin
              bit_idx   <= next_idx;
              shift_i_q <= word[next_idx];
              state     <= CFGL_SETUP;
            end else begin
              in_ready_q <= 1'b1;
              state      <= CFGL_WAIT_WORD;
            end
          end

          CFGL_FINISH: begin
            state  <= CFGL_IDLE;
            busy_q <= 1'b0;
          end

          default: state <= CFGL_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.shift_clk = shift_clk_q;
  assign bus.shift_i   = shift_i_q;
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_valid  = rb_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_loader
// Drives cfg_loader against a behavioural 36-bit shift chain. Readback words
// are predicted from the bench's own record of the chain contents and queued
// when each pass is launched; observed rb words are compared in order.
// ---------------------------------------------------------------------------
module tb_cfg_loader;
  import cfg_loader_pkg::*;

  localparam int CL     = 36;
  localparam int WW     = 8;
  localparam int NWORDS = (CL + WW - 1) / WW;
  // Cycle carrying done, counting the cycle in which start is sampled as 1.
  localparam int DONE_CYCLE = 2 * CL + NWORDS + 2;

  // CLB bits 35:32, XOR3 LUT in 31:16, AND3 LUT in 15:0.
  localparam logic [CL-1:0] PAT_A      = {4'hB, 16'h9696, 16'h8080};
  localparam logic [CL-1:0] PAT_B      = 36'hC3A5F0E71;
  localparam logic [CL-1:0] CHAIN_INIT = 36'h5A5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cfg_loader_if #(.WORD_W(WW)) bus ();

  cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural chain: head receives shift_i, tail (bit 0) feeds shift_o.
  logic [CL-1:0] chain = CHAIN_INIT;
  int            pulses = 0;
  int            si_glitch = 0;
  logic          si_neg = 1'b0;

  assign bus.shift_o = chain[0];

  always @(posedge bus.shift_clk) begin
    chain  <= {bus.shift_i, chain[CL-1:1]};
    pulses <= pulses + 1;
    if (bus.shift_i !== si_neg) si_glitch <= si_glitch + 1;
  end

  always @(negedge clk) si_neg <= bus.shift_i;

  logic [WW-1:0] obs_q[$];
  always @(negedge clk) if (bus.rb_valid === 1'b1) obs_q.push_back(bus.rb_data);

  int            n_asserts = 0;
  int            n_fail    = 0;
  logic [WW-1:0] exp_q[$];
  int            rd_idx    = 0;
  logic [CL-1:0] exp_chain = CHAIN_INIT;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Chain contents after n bits of pat were shifted into old.
  function automatic logic [CL-1:0] shifted(input logic [CL-1:0] old,
                                            input logic [CL-1:0] pat, input int n);
    logic [CL-1:0] r;
    r = (old >> n) | (pat << (CL - n));
    return r;
  endfunction

  task automatic push_rb(input logic [CL-1:0] old, input int nwords);
    for (int w = 0; w < nwords; w++) exp_q.push_back(WW'(old >> (w * WW)));
  endtask

  task automatic drain_rb(input string name);
    while (rd_idx < obs_q.size()) begin
      if (exp_q.size() == 0) check({name, " rb_unexpected"}, obs_q[rd_idx], 64'hx);
      else check({name, " rb_word"}, obs_q[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    check({name, " rb_missing"}, exp_q.size(), 0);
  endtask

  // One load pass. stall_word: hold in_valid low 10 cycles while the loader
  // waits for that word. cut_at >= 0: abort (or reset when cut_rst) while the
  // cut_at-th pulse is high. A spurious start is raised mid-pass.
  task automatic run_pass(input string name, input logic [CL-1:0] pat,
                          input int stall_word, input int cut_at,
                          input bit cut_rst, input bit chk_lat);
    logic [NWORDS*WW-1:0] padded;
    int  w, stall_cnt, p0, exp_pulses;
    bit  finished, cut_done, late_done;
    padded    = {{(NWORDS*WW-CL){1'b1}}, pat};
    p0        = pulses;
    w         = 0;
    stall_cnt = 0;
    finished  = 1'b0;
    cut_done  = 1'b0;
    late_done = 1'b0;
    exp_pulses = (cut_at < 0) ? CL : cut_at;
    push_rb(exp_chain, (cut_at < 0) ? NWORDS : cut_at / WW);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;

    for (int t = 0; t < 600 && !finished && !cut_done; t++) begin
      if (bus.done === 1'b1) begin
        finished = 1'b1;
        if (chk_lat) check({name, " done_cycle"}, t + 2, DONE_CYCLE);
      end else if (cut_at >= 0 && pulses - p0 == cut_at && bus.shift_clk === 1'b1) begin
        if (cut_rst) rst = 1'b1;
        else bus.abort = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        bus.abort = 1'b0;
        check({name, " cut_shift_clk"}, bus.shift_clk, 0);
        check({name, " cut_busy"}, bus.busy, 0);
        check({name, " cut_pulses"}, pulses - p0, cut_at);
        if (cut_rst) begin
          check({name, " rst_in_ready"}, bus.in_ready, 0);
          check({name, " rst_rb_data"}, bus.rb_data, 0);
        end
        cut_done = 1'b1;
      end else begin
        bus.start = (t == 20);
        if (w < NWORDS) bus.in_data = padded[w*WW +: WW];
        if (w == stall_word && stall_cnt < 10 && bus.in_ready === 1'b1) begin
          bus.in_valid = 1'b0;
          check({name, " stall_shift_clk"}, bus.shift_clk, 0);
          stall_cnt++;
        end else begin
          bus.in_valid = (w < NWORDS);
          if (bus.in_valid && bus.in_ready === 1'b1) w++;
        end
        @(negedge clk);
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check({name, " completed"}, (cut_at < 0) ? finished : cut_done, 1);

    if (cut_at < 0) begin
      @(negedge clk);
      check({name, " done_one_cycle"}, bus.done, 0);
      check({name, " idle_after"}, bus.busy, 0);
      exp_chain = pat;
    end else begin
      exp_chain = shifted(exp_chain, pat, cut_at);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) late_done = 1'b1;
    end
    check({name, " no_extra_done"}, late_done, 0);
    check({name, " still_idle"}, bus.busy, 0);
    check({name, " pulses"}, pulses - p0, exp_pulses);
    check({name, " chain"}, chain, exp_chain);
    drain_rb(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] b;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset shift_clk", bus.shift_clk, 0);
    check("reset shift_i", bus.shift_i, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset rb_valid", bus.rb_valid, 0);
    check("reset rb_data", bus.rb_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_pass("load_a", PAT_A, -1, -1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b = i[2:0];
      check("and3_lut", chain[i], b[0] & b[1] & b[2]);
      check("xor3_lut", chain[LUT_CONFIG_LEN + i], b[0] ^ b[1] ^ b[2]);
    end

    run_pass("stall_a", PAT_A, 3, -1, 1'b0, 1'b0);
    run_pass("load_b", PAT_B, -1, -1, 1'b0, 1'b0);
    run_pass("abort_a", PAT_A, -1, 17, 1'b0, 1'b0);
    run_pass("reload_b", PAT_B, -1, -1, 1'b0, 1'b1);
    run_pass("rst_a", PAT_A, -1, 5, 1'b1, 1'b0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort busy", bus.busy, 0);
    check("start_abort in_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("start_abort still_idle", bus.busy, 0);

    run_pass("final_a", PAT_A, -1, -1, 1'b0, 1'b1);
    check("shift_i stable at shift_clk rise", si_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
